// File: rtl/ps2_host_tx_if.sv
// Command handshake between the synth core and the PS/2 host transmitter.
//   cmd_data  : command byte offered by the core
//   cmd_valid : core has a command to send
//   cmd_ready : transmitter is idle and will take a command this cycle
//   done      : one-cycle pulse, byte sent and device acknowledged it
//   error     : one-cycle pulse, device refused the byte or went silent
// master = command source (synth core), slave = the transmitter.
`timescale 1ns/1ps

interface ps2_host_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       done;
    logic       error;

    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready,
        input  done,
        input  error
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Sends one 8-bit command to the
// keyboard over the shared open-drain PS2_CLK/PS2_DAT lines: inhibit the clock,
// assert the start bit, then shift data/parity/stop on device clock falls and
// check the device's ACK.
// Ports:
//   CLOCK_50   : 50 MHz system clock, rising edge
//   resetn     : asynchronous active-low reset
//   cmd        : command handshake (slave side), see ps2_host_tx_if
//   ps2_clk_in : PS2_CLK pin value (asynchronous)
//   ps2_dat_in : PS2_DAT pin value (asynchronous)
//   ps2_clk_oe : 1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe : 1 = pull PS2_DAT low, 0 = release
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    ps2_host_tx_if.slave    cmd,
    input  logic            ps2_clk_in,
    input  logic            ps2_dat_in,
    output logic            ps2_clk_oe,
    output logic            ps2_dat_oe
);

    // One counter serves both the inhibit interval and the edge timeout,
    // so it is sized for whichever is larger.
    localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        WAIT_IDLE
    } state_t;

    state_t         state, state_next;
    logic [7:0]     cmd_reg, cmd_next;
    logic           parity, parity_next;
    logic [3:0]     bitcnt, bitcnt_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           dat_drive, dat_drive_next;
    logic           ack, ack_next;

    logic           clk_meta, clk_sync, clk_prev;
    logic           dat_meta, dat_sync;
    logic           fall;
    logic           timeout;

    logic           ready_c, done_c, error_c, clk_oe_c, dat_oe_c;

    // Two-flop synchronisers for both pins plus one extra clock stage for
    // falling-edge detection. They reset to 1 (idle bus) so leaving reset
    // never looks like a device clock fall.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
        end
    end

    assign fall    = clk_prev & ~clk_sync;
    assign timeout = (cnt == TO_LIMIT);

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cmd_reg   <= '0;
            parity    <= 1'b0;
            bitcnt    <= '0;
            cnt       <= '0;
            dat_drive <= 1'b0;
            ack       <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_reg   <= cmd_next;
            parity    <= parity_next;
            bitcnt    <= bitcnt_next;
            cnt       <= cnt_next;
            dat_drive <= dat_drive_next;
            ack       <= ack_next;
        end
    end

    // Next-state and output logic. done/error are asserted in the last cycle
    // of the transfer (the one that returns to IDLE), so cmd_ready rises in
    // the following cycle. A timeout wins over a clock fall or a bus release
    // seen in the same cycle and forces both lines released.
    always_comb begin
        state_next     = state;
        cmd_next       = cmd_reg;
        parity_next    = parity;
        bitcnt_next    = bitcnt;
        cnt_next       = cnt;
        dat_drive_next = dat_drive;
        ack_next       = ack;
        ready_c        = 1'b0;
        done_c         = 1'b0;
        error_c        = 1'b0;
        clk_oe_c       = 1'b0;
        dat_oe_c       = 1'b0;

        case (state)
            IDLE: begin
                ready_c  = 1'b1;
                cnt_next = '0;
                if (cmd.cmd_valid) begin
                    cmd_next    = cmd.cmd_data;
                    parity_next = ~^cmd.cmd_data;
                    state_next  = INHIBIT;
                end
            end

            INHIBIT: begin
                clk_oe_c = 1'b1;
                if (cnt == INH_LAST) begin
                    cnt_next   = '0;
                    state_next = REQ;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            REQ: begin
                clk_oe_c       = 1'b1;
                dat_oe_c       = 1'b1;
                dat_drive_next = 1'b1;
                bitcnt_next    = '0;
                cnt_next       = '0;
                state_next     = XFER;
            end

            XFER: begin
                if (timeout) begin
                    error_c    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    dat_oe_c = dat_drive;
                    if (fall) begin
                        cnt_next    = '0;
                        bitcnt_next = bitcnt + 1'b1;
                        if (bitcnt < 4'd8) begin
                            dat_drive_next = ~cmd_reg[bitcnt[2:0]];
                        end else if (bitcnt == 4'd8) begin
                            dat_drive_next = ~parity;
                        end else if (bitcnt == 4'd9) begin
                            dat_drive_next = 1'b0;
                        end else begin
                            // Device pulls data low to acknowledge.
                            ack_next       = ~dat_sync;
                            dat_drive_next = 1'b0;
                            state_next     = WAIT_IDLE;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                if (timeout) begin
                    error_c    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (clk_sync && dat_sync) begin
                    done_c     = ack;
                    error_c    = ~ack;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (fall) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready = ready_c;
    assign cmd.done      = done_c;
    assign cmd.error     = error_c;
    assign ps2_clk_oe    = clk_oe_c;
    assign ps2_dat_oe    = dat_oe_c;

endmodule
